park_keypad_entry: RTL

//  Driver side of the parking-gate password interface. Captures two 2-bit digits from a raw keypad,

---
 rtl/park_pkg.sv | 27 ++
 rtl/park_key_debounce.sv | 53 +++++
 rtl/park_keypad_entry.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/park_pkg.sv
// ============================================================================
// park_pkg
// Shared types and constants for the parking-gate password path.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package park_pkg;

    localparam int PW_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM_D1  = 2'd1,
        ARM_D2  = 2'd2,
        PRESENT = 2'd3
    } park_state_t;

    // Width of a counter that must hold the value n without wrapping.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/park_key_debounce.sv
// ============================================================================
// park_key_debounce
// Debounces the raw key-down level and emits a one-cycle press strobe.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module park_key_debounce
    import park_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int               CNT_W  = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;

    // r_cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (i_raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt >= C_LAST) begin
                r_cnt   <= '0;
                r_level <= i_raw;
                r_press <= i_raw;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/park_keypad_entry.sv
// ============================================================================
// park_keypad_entry
// Captures two keypad digits while a car is at the entrance and presents them
// to the gate controller for a fixed hold window.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module park_keypad_entry
    import park_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int HOLD_CYCLES     = 100
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sensor_entrance,
    input  logic            key_valid,
    input  logic [PW_W-1:0] key_code,
    input  logic            key_clear,
    output logic [PW_W-1:0] password_1,
    output logic [PW_W-1:0] password_2,
    output logic            pw_valid,
    output logic            busy,
    output logic            entry_err
);

    localparam int               TMO_W       = cnt_w(TIMEOUT_CYCLES);
    localparam int               HOLD_W      = cnt_w(HOLD_CYCLES);
    localparam logic [TMO_W-1:0]  C_TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    park_state_t       r_state;
    logic [PW_W-1:0]   r_d1;
    logic [PW_W-1:0]   r_d2;
    logic [TMO_W-1:0]  r_tmo;
    logic [HOLD_W-1:0] r_hold;
    logic [PW_W-1:0]   r_pw1;
    logic [PW_W-1:0]   r_pw2;
    logic              r_pw_valid;
    logic              r_busy;
    logic              r_err;

    park_state_t       w_next;
    logic [PW_W-1:0]   w_d1;
    logic [PW_W-1:0]   w_d2;
    logic [TMO_W-1:0]  w_tmo;
    logic [HOLD_W-1:0] w_hold;
    logic              w_tmo_hit;
    logic              w_err;
    logic              w_level;
    logic              w_press;
    logic              w_accept;

    park_key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (key_valid),
        .o_level (w_level),
        .o_press (w_press)
    );

    assign w_accept = w_press & w_level;

    always_comb begin
        w_next    = r_state;
        w_d1      = r_d1;
        w_d2      = r_d2;
        w_err     = 1'b0;
        w_hold    = '0;
        w_tmo_hit = (r_tmo >= C_TMO_LAST);
        w_tmo     = w_tmo_hit ? r_tmo : r_tmo + 1'b1;

        // Priority within the armed states: clear, then press, then timeout.
        case (r_state)
            IDLE: begin
                if (sensor_entrance) begin
                    w_next = ARM_D1;
                end
            end
            ARM_D1: begin
                if (key_clear) begin
                    w_tmo = '0;
                end else if (w_accept) begin
                    w_d1   = key_code;
                    w_next = ARM_D2;
                end else if (w_tmo_hit) begin
                    w_next = IDLE;
                    w_err  = 1'b1;
                end
            end
            ARM_D2: begin
                if (key_clear) begin
                    w_d1   = '0;
                    w_next = ARM_D1;
                end else if (w_accept) begin
                    w_d2   = key_code;
                    w_next = PRESENT;
                end else if (w_tmo_hit) begin
                    w_next = IDLE;
                    w_err  = 1'b1;
                end
            end
            PRESENT: begin
                if (r_hold >= C_HOLD_LAST) begin
                    w_next = IDLE;
                end else begin
                    w_hold = r_hold + 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        if ((w_next != r_state) || (r_state == IDLE) || (r_state == PRESENT)) begin
            w_tmo = '0;
        end
        if (w_next == IDLE) begin
            w_d1 = '0;
            w_d2 = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_d1       <= '0;
            r_d2       <= '0;
            r_tmo      <= '0;
            r_hold     <= '0;
            r_pw1      <= '0;
            r_pw2      <= '0;
            r_pw_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_d1       <= w_d1;
            r_d2       <= w_d2;
            r_tmo      <= w_tmo;
            r_hold     <= w_hold;
            r_pw1      <= (w_next == PRESENT) ? w_d1 : '0;
            r_pw2      <= (w_next == PRESENT) ? w_d2 : '0;
            r_pw_valid <= (w_next == PRESENT);
            r_busy     <= (w_next != IDLE);
            r_err      <= w_err;
        end
    end

    assign password_1 = r_pw1;
    assign password_2 = r_pw2;
    assign pw_valid   = r_pw_valid;
    assign busy       = r_busy;
    assign entry_err  = r_err;

endmodule

`default_nettype wire
